iob_timer_mc: RTL and testbench
===============================

// Module: iob_timer_mc
// PURPOSE
//  Multi-channel programmable timer: N_CH independent down-counters sharing one
//  prescaled tick, with one-shot or periodic auto-reload and a per-channel
//  expiry flag that drives a combined interrupt. Sits on the CPU native slave
//  bus beside the free-running 64-bit timer and serves as the system's
//  event/interrupt timer.
// PARAMETERS
//  N_CH     4   number of timer channels (1..8)
//  CNT_W    32  channel counter / LOAD width (<= DATA_W)
//  PRESC_W  16  prescaler register width
//  DATA_W   32  bus data width
//  ADDR_W   6   word-address width (>= clog2(4*N_CH+2))
// PORTS
//  clk      in   1          system clock
//  rst_n    in   1          asynchronous reset, active-low
//  valid    in   1          bus request
//  address  in   ADDR_W     word address
//  wdata    in   DATA_W     write data
//  wstrb    in   DATA_W/8   byte strobes; any bit set = write, all zero = read
//  rdata    out  DATA_W     read data, valid when ready=1
//  ready    out  1          request acknowledge
//  irq      out  1          OR of (EXP[i] & IRQ_EN[i]) over all channels
// BEHAVIOUR
//  Reset (rst_n=0, async): all registers, counters, prescaler = 0; rdata=0,
//   ready=0, irq=0. Reset mid-count discards all state; no expiry is flagged.
//  Register map (word addr): ch i base = 4*i
//   +0 CTRL  RW [0]EN [1]PERIODIC [2]IRQ_EN, other bits read 0
//   +1 LOAD  RW CNT_W bits; a write also loads COUNT_i <= wdata next cycle
//   +2 COUNT RO current count; writes ignored
//   +3 STAT  [0]EXP, write-1-to-clear
//   4*N_CH   PRESC RW; a write also clears the prescaler counter
//   4*N_CH+1 IRQSUM RO, bit i = EXP[i]; unmapped addresses read 0, writes ignored
//  Bus: every valid gets ready=1 exactly one cycle later (single-cycle pulse);
//   rdata is registered with ready and reads 0 otherwise. A write takes effect
//   on the clock edge where valid is sampled. Back-to-back requests are
//   accepted every cycle.
//  Prescaler: p counts 0..PRESC; tick=1 in the cycle p==PRESC, then p<=0.
//   PRESC=0 gives a tick every cycle. The prescaler always runs after reset.
//  Channel on tick, EN=1, COUNT>0: COUNT <= COUNT-1.
//   If COUNT==1: EXP<=1. If PERIODIC, COUNT<=LOAD. Else COUNT<=0 and EN<=0 (hw clear).
//   COUNT==0 with EN=1: no decrement and no expiry (LOAD=0 disables the channel).
//   EN=0: COUNT holds its value. Setting EN again resumes from the held COUNT.
//  Simultaneous events, same cycle:
//   expiry + STAT W1C: set wins, EXP stays 1.
//   expiry + LOAD write: the write wins, COUNT<=wdata, and EXP is still set.
//   expiry (one-shot hw EN clear) + CTRL write: the written CTRL value wins.
//  irq is combinational from registered EXP and IRQ_EN; no extra latency.
//  Arithmetic is unsigned. COUNT never wraps below 0. LOAD is truncated to CNT_W.
// TESTING
//  1 Reset: rst_n=0 mid-count -> all reads 0, irq=0. After release: ready one
//    cycle after valid, and back-to-back reads ack every cycle.
//  2 One-shot: PRESC=0, LOAD0=3, CTRL0=0b101 -> COUNT0 reads 3,2,1,0. EXP0=1
//    and irq=1 on cycle 3. CTRL0.EN reads 0. COUNT0 stays 0.
//  3 Periodic plus prescale: PRESC=4, LOAD1=2, CTRL1=0b011 -> EXP1 sets every
//    10 cycles, COUNT1 reloads to 2, irq stays 0 (IRQ_EN=0). IRQSUM=0b0010.
//  4 W1C race: STAT0=1 written in the expiry cycle -> EXP0 stays 1. A later
//    W1C -> EXP0=0 and irq=0.
//  5 Multi-channel: ch0 LOAD=5, ch3 LOAD=7, both periodic, IRQ_EN on ->
//    independent EXP timing. irq stays high until both flags are cleared.
//  6 Edge cases: LOAD=0 with EN=1 -> never expires. Pause EN at COUNT=4, then
//    resume -> continues 3,2,1. Unmapped read -> 0.

Source files
------------

// File: rtl/iob_timer_mc.sv
// Multi-channel programmable down-counter timer on the native slave bus.
// Every channel uses the same prescaled tick. Each channel can be one-shot
// or periodic, and each one has a sticky expiry flag that feeds the combined irq.
module iob_timer_mc #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PRESC_W = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic                  irq
);

    localparam int unsigned CH_AW = ADDR_W - 2;

    localparam logic [ADDR_W-1:0] PRESC_ADDR  = ADDR_W'(4 * N_CH);
    localparam logic [ADDR_W-1:0] IRQSUM_ADDR = ADDR_W'(4 * N_CH + 1);

    localparam logic [1:0] OFF_CTRL  = 2'd0;
    localparam logic [1:0] OFF_LOAD  = 2'd1;
    localparam logic [1:0] OFF_COUNT = 2'd2;
    localparam logic [1:0] OFF_STAT  = 2'd3;

    logic [N_CH-1:0]    en;
    logic [N_CH-1:0]    periodic;
    logic [N_CH-1:0]    irq_en;
    logic [N_CH-1:0]    expired;
    logic [CNT_W-1:0]   load  [N_CH];
    logic [CNT_W-1:0]   count [N_CH];
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;

    logic               wr_c;
    logic               tick_c;
    logic [N_CH-1:0]    ch_sel_c;
    logic [N_CH-1:0]    expire_c;
    logic [DATA_W-1:0]  rd_c;

    assign wr_c   = valid & (|wstrb);
    assign tick_c = (pcnt == presc);
    assign irq    = |(expired & irq_en);

    // Decode the channel that the request targets, and find the channels that reach zero on this tick.
    always_comb begin
        ch_sel_c = '0;
        expire_c = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            ch_sel_c[i] = valid && (address[ADDR_W-1:2] == CH_AW'(i));
            expire_c[i] = tick_c && en[i] && (count[i] == CNT_W'(1));
        end
    end

    // Read data mux. A request to an address that no register uses gets 0.
    always_comb begin
        rd_c = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ch_sel_c[i]) begin
                case (address[1:0])
                    OFF_CTRL:  rd_c = DATA_W'({irq_en[i], periodic[i], en[i]});
                    OFF_LOAD:  rd_c = DATA_W'(load[i]);
                    OFF_COUNT: rd_c = DATA_W'(count[i]);
                    OFF_STAT:  rd_c = DATA_W'(expired[i]);
                    default:   rd_c = '0;
                endcase
            end
        end
        if (address == PRESC_ADDR) begin
            rd_c = DATA_W'(presc);
        end else if (address == IRQSUM_ADDR) begin
            rd_c = DATA_W'(expired);
        end
    end

    // Bus response: ready is a one-cycle pulse after each request. rdata is 0 except on a read ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= valid;
            rdata <= (valid && !wr_c) ? rd_c : '0;
        end
    end

    // Shared prescaler. A write to PRESC restarts the prescaler phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            pcnt  <= '0;
        end else if (wr_c && (address == PRESC_ADDR)) begin
            presc <= wdata[PRESC_W-1:0];
            pcnt  <= '0;
        end else if (tick_c) begin
            pcnt  <= '0;
        end else begin
            pcnt  <= pcnt + PRESC_W'(1);
        end
    end

    // Channel state. The order of the statements sets the priority:
    // hardware count update, then a bus write, then the expiry set, which beats W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= '0;
            periodic <= '0;
            irq_en   <= '0;
            expired  <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                load[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (tick_c && en[i] && (count[i] != '0)) begin
                    if (count[i] == CNT_W'(1)) begin
                        if (periodic[i]) begin
                            count[i] <= load[i];
                        end else begin
                            count[i] <= '0;
                            en[i]    <= 1'b0;
                        end
                    end else begin
                        count[i] <= count[i] - CNT_W'(1);
                    end
                end
                if (wr_c && ch_sel_c[i]) begin
                    case (address[1:0])
                        OFF_CTRL: begin
                            en[i]       <= wdata[0];
                            periodic[i] <= wdata[1];
                            irq_en[i]   <= wdata[2];
                        end
                        OFF_LOAD: begin
                            load[i]  <= wdata[CNT_W-1:0];
                            count[i] <= wdata[CNT_W-1:0];
                        end
                        OFF_STAT: begin
                            if (wdata[0]) begin
                                expired[i] <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
                if (expire_c[i]) begin
                    expired[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iob_timer_mc.sv
// Testbench for iob_timer_mc. It runs directed scenarios and then a random bus traffic phase.
// Every cycle it checks ready, rdata and irq against a behavioural timer model.
module tb_iob_timer_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [5:0]  address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] last_rd;

    // Behavioural model state
    int unsigned m_p;
    int unsigned m_presc;
    logic [31:0] m_load [4];
    logic [31:0] m_cnt  [4];
    bit          m_en   [4];
    bit          m_per  [4];
    bit          m_ie   [4];
    bit          m_exp  [4];

    always #5 clk = ~clk;

    iob_timer_mc #(
        .N_CH(4), .CNT_W(32), .PRESC_W(16), .DATA_W(32), .ADDR_W(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .address(address),
        .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic void model_reset();
        m_p = 0;
        m_presc = 0;
        for (int c = 0; c < 4; c++) begin
            m_load[c] = 0; m_cnt[c] = 0;
            m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_exp[c] = 0;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [5:0] a);
        logic [1:0] c;
        c = a[3:2];
        if (a < 6'd16) begin
            case (a[1:0])
                2'd0:    return {29'd0, m_ie[c], m_per[c], m_en[c]};
                2'd1:    return m_load[c];
                2'd2:    return m_cnt[c];
                default: return {31'd0, m_exp[c]};
            endcase
        end
        if (a == 6'd16) return m_presc;
        if (a == 6'd17) return {28'd0, m_exp[3], m_exp[2], m_exp[1], m_exp[0]};
        return 32'd0;
    endfunction

    function automatic bit model_irq();
        bit r = 0;
        for (int c = 0; c < 4; c++) r |= m_exp[c] & m_ie[c];
        return r;
    endfunction

    function automatic bit will_expire(input int c);
        return (m_p == m_presc) && m_en[c] && (m_cnt[c] == 32'd1);
    endfunction

    // One clock of the timer, computed from the rules the timer must follow.
    function automatic void model_step(input bit v, input bit w, input logic [5:0] a, input logic [31:0] d);
        bit tick;
        bit fired [4];
        logic [1:0] c;
        tick = (m_p == m_presc);
        m_p = tick ? 0 : m_p + 1;
        for (int k = 0; k < 4; k++) begin
            fired[k] = 0;
            if (tick && m_en[k] && m_cnt[k] != 0) begin
                m_cnt[k] = m_cnt[k] - 1;
                if (m_cnt[k] == 0) begin
                    fired[k] = 1;
                    m_exp[k] = 1;
                    if (m_per[k]) m_cnt[k] = m_load[k];
                    else m_en[k] = 0;
                end
            end
        end
        if (v && w) begin
            c = a[3:2];
            if (a < 6'd16) begin
                case (a[1:0])
                    2'd0: begin m_en[c] = d[0]; m_per[c] = d[1]; m_ie[c] = d[2]; end
                    2'd1: begin m_load[c] = d; m_cnt[c] = d; end
                    2'd3: if (d[0] && !fired[c]) m_exp[c] = 0;
                    default: ;
                endcase
            end else if (a == 6'd16) begin
                m_presc = {16'd0, d[15:0]};
                m_p = 0;
            end
        end
    endfunction

    // One bus cycle. The task drives a request, moves the model one cycle, and checks the response after the edge.
    task automatic bus(input bit v, input bit w, input logic [5:0] a, input logic [31:0] d);
        logic [31:0] erd;
        bit eirq;
        valid   = v;
        wstrb   = w ? 4'($urandom_range(1, 15)) : 4'b0;
        address = a;
        wdata   = d;
        erd = (v && !w) ? model_read(a) : 32'd0;
        model_step(v, w, a, d);
        eirq = model_irq();
        @(posedge clk);
        #1;
        valid = 1'b0;
        wstrb = 4'b0;
        check("ready", 32'(ready), 32'(v));
        check("rdata", rdata, erd);
        check("irq", 32'(irq), 32'(eirq));
        last_rd = rdata;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        bus(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [5:0] a);
        bus(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) bus(1'b0, 1'b0, 6'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] seq_want [4];
        bit hit;
        bit rv;
        bit rw;
        logic [5:0] ra;
        logic [31:0] rdat;

        rst_n = 1'b0; valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of counting
        wr(6'd16, 32'd0);
        wr(6'd1, 32'd9);
        wr(6'd0, 32'd7);
        idle(3);
        rd(6'd2);
        rst_n = 1'b0;
        model_reset();
        #2;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int a = 0; a < 18; a++) begin
            rd(6'(a));
            check("rst_readback", last_rd, 32'd0);
        end

        // One-shot timer with PRESC = 0
        wr(6'd16, 32'd0);
        wr(6'd1, 32'd3);
        wr(6'd0, 32'd5);
        rd(6'd2); check("os_cnt_a", last_rd, 32'd3);
        rd(6'd2); check("os_cnt_b", last_rd, 32'd2);
        check("os_irq_early", 32'(irq), 32'd0);
        rd(6'd2); check("os_cnt_c", last_rd, 32'd1);
        check("os_irq_set", 32'(irq), 32'd1);
        rd(6'd2); check("os_cnt_d", last_rd, 32'd0);
        rd(6'd0); check("os_ctrl_hwclr", last_rd, 32'd4);
        rd(6'd3); check("os_stat", last_rd, 32'd1);
        idle(5);
        rd(6'd2); check("os_cnt_hold", last_rd, 32'd0);

        // Periodic channel with the prescaler active. IRQ_EN stays off.
        wr(6'd3, 32'd1);
        wr(6'd16, 32'd4);
        wr(6'd5, 32'd2);
        wr(6'd4, 32'd3);
        idle(35);
        rd(6'd17); check("per_irqsum", last_rd, 32'd2);
        check("per_irq_off", 32'(irq), 32'd0);

        // W1C written in the same cycle as an expiry
        wr(6'd1, 32'd3);
        wr(6'd0, 32'd7);
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            if (will_expire(0)) begin
                wr(6'd3, 32'd1);
                hit = 1;
            end else begin
                idle(1);
            end
        end
        check("race_window_found", 32'(hit), 32'd1);
        rd(6'd3); check("race_exp_kept", last_rd, 32'd1);
        wr(6'd0, 32'd4);
        wr(6'd3, 32'd1);
        rd(6'd3); check("race_exp_cleared", last_rd, 32'd0);
        check("race_irq_low", 32'(irq), 32'd0);

        // Two periodic channels with different reload values
        wr(6'd16, 32'd0);
        wr(6'd1, 32'd5);
        wr(6'd13, 32'd7);
        wr(6'd0, 32'd7);
        wr(6'd12, 32'd7);
        idle(40);
        wr(6'd0, 32'd4);
        wr(6'd12, 32'd4);
        wr(6'd3, 32'd1);
        check("mc_irq_held", 32'(irq), 32'd1);
        wr(6'd15, 32'd1);
        check("mc_irq_clear", 32'(irq), 32'd0);

        // Edge cases: LOAD = 0, pause and resume, unmapped addresses
        wr(6'd9, 32'd0);
        wr(6'd8, 32'd7);
        idle(20);
        rd(6'd11); check("load0_never_exp", last_rd, 32'd0);
        wr(6'd8, 32'd0);
        wr(6'd9, 32'd8);
        wr(6'd8, 32'd5);
        hit = 0;
        for (int k = 0; k < 50 && !hit; k++) begin
            if (m_cnt[2] == 32'd5) begin
                wr(6'd8, 32'd4);
                hit = 1;
            end else begin
                idle(1);
            end
        end
        check("pause_window_found", 32'(hit), 32'd1);
        idle(3);
        rd(6'd10); check("pause_hold", last_rd, 32'd4);
        wr(6'd8, 32'd5);
        seq_want[0] = 32'd4; seq_want[1] = 32'd3; seq_want[2] = 32'd2; seq_want[3] = 32'd1;
        for (int k = 0; k < 4; k++) begin
            rd(6'd10);
            check("resume_seq", last_rd, seq_want[k]);
        end
        rd(6'd20); check("unmapped_20", last_rd, 32'd0);
        rd(6'd63); check("unmapped_63", last_rd, 32'd0);

        // Random bus traffic
        for (int k = 0; k < 1500; k++) begin
            rv = ($urandom_range(0, 3) != 0);
            rw = 1'($urandom_range(0, 1));
            ra = 6'($urandom_range(0, 21));
            rdat = $urandom;
            if (ra < 6'd16 && ra[1:0] == 2'd1) rdat = $urandom_range(0, 12);
            if (ra == 6'd16) rdat = $urandom_range(0, 3);
            bus(rv, rw, ra, rdat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
